dmem_arbiter: RTL

- Two-requester arbiter and sequencer for the single-port data memory.
- Requester 0 is the core load/store unit; requester 1 is the debug/DMA port.
- Accepts one request at a time with valid/ready handshakes and round-robin fairness.
- Drives the memory address/data/store-enable for exactly one cycle, then returns read data (or an error) on a held response channel with backpressure.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access types, FSM states and requester IDs.
package dmem_pkg;

    localparam int unsigned NUM_REQ = 2;

    localparam logic [1:0] RWE_LD = 2'd0;
    localparam logic [1:0] RWE_SB = 2'd1;
    localparam logic [1:0] RWE_SH = 2'd2;
    localparam logic [1:0] RWE_SW = 2'd3;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; the caller owns the last-grant register.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o_c,
    output logic       gnt_id_o_c
);

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant_o_c  = 2'b00;
        gnt_id_o_c = ID_M0;
        unique case (valid_i)
            2'b01:   gnt_id_o_c = ID_M0;
            2'b10:   gnt_id_o_c = ID_M1;
            2'b11:   gnt_id_o_c = ~last_grant_i;
            default: gnt_id_o_c = ID_M0;
        endcase
        if (valid_i != 2'b00) begin
            grant_o_c = id_to_onehot(gnt_id_o_c);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester sequencer for the single-port data memory: arbitrate, drive the
// memory port for one cycle, then hold the response until the requester takes it.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [1:0]        m0_rwe,
    output logic              m0_rsp_valid,
    input  logic              m0_rsp_ready,
    output logic [DATA_W-1:0] m0_rsp_rdata,
    output logic              m0_rsp_err,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [1:0]        m1_rwe,
    output logic              m1_rsp_valid,
    input  logic              m1_rsp_ready,
    output logic [DATA_W-1:0] m1_rsp_rdata,
    output logic              m1_rsp_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_rwe,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                gnt_id_q, gnt_id_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]          mem_rwe_q, mem_rwe_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]  rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q [NUM_REQ];
    logic [DATA_W-1:0]   rsp_rdata_d [NUM_REQ];

    logic [NUM_REQ-1:0]  req_valid;
    logic [NUM_REQ-1:0]  rsp_ready;
    logic [NUM_REQ-1:0]  req_ready_c;
    logic [NUM_REQ-1:0]  arb_grant_c;
    logic                arb_id_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]   sel_wdata_c;
    logic [1:0]          sel_rwe_c;
    logic                sel_oor_c;

    assign req_valid = {m1_req_valid, m0_req_valid};
    assign rsp_ready = {m1_rsp_ready, m0_rsp_ready};

    rr_arb2 u_arb (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o_c    (arb_grant_c),
        .gnt_id_o_c   (arb_id_c)
    );

    // Request payload of whichever port the picker selected.
    assign sel_addr_c  = (arb_id_c == ID_M1) ? m1_addr  : m0_addr;
    assign sel_wdata_c = (arb_id_c == ID_M1) ? m1_wdata : m0_wdata;
    assign sel_rwe_c   = (arb_id_c == ID_M1) ? m1_rwe   : m0_rwe;
    assign sel_oor_c   = (sel_addr_c >= DEPTH_A);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        err_d        = err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rwe_d    = mem_rwe_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        req_ready_c  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid != '0) begin
                    req_ready_c  = arb_grant_c;
                    mem_addr_d   = sel_addr_c;
                    mem_wdata_d  = sel_wdata_c;
                    // Out-of-range accesses never reach the memory as stores.
                    mem_rwe_d    = sel_oor_c ? RWE_LD : sel_rwe_c;
                    err_d        = sel_oor_c;
                    gnt_id_d     = arb_id_c;
                    last_grant_d = arb_id_c;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // mem_rdata is the pre-store word; the store commits on this same edge.
                mem_rwe_d              = RWE_LD;
                rsp_valid_d[gnt_id_q]  = 1'b1;
                rsp_err_d[gnt_id_q]    = err_q;
                rsp_rdata_d[gnt_id_q]  = err_q ? '0 : mem_rdata;
                state_d                = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[gnt_id_q]) begin
                    rsp_valid_d[gnt_id_q] = 1'b0;
                    state_d               = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_M1;
            gnt_id_q     <= ID_M0;
            err_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rwe_q    <= RWE_LD;
            rsp_valid_q  <= '0;
            rsp_err_q    <= '0;
            rsp_rdata_q  <= '{default: '0};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            err_q        <= err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rwe_q    <= mem_rwe_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign m0_req_ready = req_ready_c[0];
    assign m1_req_ready = req_ready_c[1];
    assign m0_rsp_valid = rsp_valid_q[0];
    assign m1_rsp_valid = rsp_valid_q[1];
    assign m0_rsp_err   = rsp_err_q[0];
    assign m1_rsp_err   = rsp_err_q[1];
    assign m0_rsp_rdata = rsp_rdata_q[0];
    assign m1_rsp_rdata = rsp_rdata_q[1];
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_rwe      = mem_rwe_q;

endmodule
